// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-lock key entry front end.
package combo_pkg;

  localparam int CODE_W              = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REJECT,
    RELEASE_DB
  } state_t;

  // True when exactly one key bit is set.
  function automatic logic is_onehot(input logic [CODE_W-1:0] v);
    return (v != '0) && ((v & (v - {{(CODE_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/combo_sync2.sv
// Two-flop synchroniser for asynchronous inputs, cleared by the async active-low reset.
module combo_sync2
  import combo_pkg::*;
#(
  parameter int WIDTH = CODE_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/combo_key_entry.sv
// Debounces four raw push buttons and hands single-key presses to the lock as a
// held one-hot code plus a one-cycle strobe; multi-key presses are flagged and dropped.
module combo_key_entry
  import combo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CODE_W-1:0] btn_in,
  input  logic              clear_count,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              multi_err,
  output logic              busy,
  output logic [CNT_W-1:0]  press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CODE_W-1:0] sync_p1;
  state_t            state, state_nxt;
  logic [CODE_W-1:0] cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              valid_nxt;
  logic              err_nxt;
  logic              accept;

  combo_sync2 #(.WIDTH(CODE_W)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (btn_in),
    .q   (sync_p1)
  );

  // Stage p1 -> state: debounce FSM on the synchronised buttons
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = code_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        code_nxt = '0;
        if (sync_p1 != '0) begin
          cand_nxt  = sync_p1;
          cnt_nxt   = '0;
          state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (sync_p1 != cand) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          if (is_onehot(cand)) begin
            state_nxt = PRESSED;
            code_nxt  = cand;
            valid_nxt = 1'b1;
            accept    = 1'b1;
          end else begin
            state_nxt = REJECT;
            code_nxt  = '0;
            err_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        // Extra or swapped keys while held are ignored; only a full release counts.
        code_nxt = cand;
        if (sync_p1 == '0) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE_DB;
        end
      end
      REJECT: begin
        code_nxt = '0;
        if (sync_p1 == '0) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (sync_p1 != '0) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          code_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        code_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State -> outputs: every output is a flop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      multi_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      code_out   <= code_nxt;
      code_valid <= valid_nxt;
      multi_err  <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Clear takes priority over a same-cycle acceptance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      press_count <= '0;
    end else if (clear_count) begin
      press_count <= '0;
    end else if (accept) begin
      press_count <= press_count + CNT_W'(1);
    end
  end

endmodule
